// File: rtl/video_crop_win_if.sv
// Video stream bundle for the crop/mask window stage.
// The slave side is the crop block: it consumes vs_i/de_i/data_i and
// produces the delayed stream together with the window-relative markers.
interface video_crop_win_if #(
    parameter int DATA_WIDTH = 24
) ();
    logic                  vs_i;
    logic                  de_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  vs_o;
    logic                  de_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  sof_o;
    logic                  eol_o;
    logic                  eof_o;

    modport slave (
        input  vs_i, de_i, data_i,
        output vs_o, de_o, data_o, sof_o, eol_o, eof_o
    );

    modport master (
        output vs_i, de_i, data_i,
        input  vs_o, de_o, data_o, sof_o, eol_o, eof_o
    );
endinterface

// File: rtl/video_crop_win.sv
// Rectangular window selector for a DE/VS pixel stream.
// Crop mode forwards only in-window pixels; mask mode keeps full-frame
// timing and replaces out-of-window pixels with FILL_VALUE.
// The window is staged on cfg_update and copied into the active (shadow)
// set on the next vs_i rising edge, so a frame never sees a partial change.
// All outputs are registered, one cycle behind the inputs.
module video_crop_win #(
    parameter int                    H_DISP     = 1280,
    parameter int                    V_DISP     = 720,
    parameter int                    X_WIDTH    = 12,
    parameter int                    Y_WIDTH    = 12,
    parameter int                    DATA_WIDTH = 24,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [X_WIDTH-1:0] cfg_start_x,
    input  logic [Y_WIDTH-1:0] cfg_start_y,
    input  logic [X_WIDTH-1:0] cfg_end_x,
    input  logic [Y_WIDTH-1:0] cfg_end_y,
    input  logic               cfg_mode,
    input  logic               cfg_update,
    output logic               cfg_err,
    video_crop_win_if.slave    vid
);

    localparam logic [X_WIDTH-1:0] H_MAX  = X_WIDTH'(H_DISP);
    localparam logic [Y_WIDTH-1:0] V_MAX  = Y_WIDTH'(V_DISP);
    localparam logic [X_WIDTH-1:0] H_LAST = X_WIDTH'(H_DISP - 1);
    localparam logic [Y_WIDTH-1:0] V_LAST = Y_WIDTH'(V_DISP - 1);
    localparam logic               MODE_CROP = 1'b0;

    typedef struct packed {
        logic [X_WIDTH-1:0] sx;
        logic [Y_WIDTH-1:0] sy;
        logic [X_WIDTH-1:0] ex;
        logic [Y_WIDTH-1:0] ey;
        logic               mode;
    } win_t;

    localparam win_t WIN_RESET = '{sx: '0, sy: '0, ex: H_MAX, ey: V_MAX, mode: MODE_CROP};

    // Right/bottom edges beyond the active area are pulled back to it.
    function automatic logic [X_WIDTH-1:0] clamp_x(input logic [X_WIDTH-1:0] v);
        return (v > H_MAX) ? H_MAX : v;
    endfunction

    function automatic logic [Y_WIDTH-1:0] clamp_y(input logic [Y_WIDTH-1:0] v);
        return (v > V_MAX) ? V_MAX : v;
    endfunction

    // An empty window (after clamping) selects nothing.
    function automatic logic win_invalid(input win_t w);
        return (w.sx >= clamp_x(w.ex)) || (w.sy >= clamp_y(w.ey));
    endfunction

    win_t cfg_in;
    assign cfg_in = {cfg_start_x, cfg_start_y, cfg_end_x, cfg_end_y, cfg_mode};

    // Configuration state
    win_t stg_q, stg_d;
    win_t shd_q, shd_d;
    logic pending_q, pending_d;
    logic vs_prev_q, vs_prev_d;
    logic cfg_err_q, cfg_err_d;

    // Pixel position within the frame
    logic [X_WIDTH-1:0] x_q, x_d;
    logic [Y_WIDTH-1:0] y_q, y_d;

    // Registered outputs
    logic                  vs_o_q, vs_o_d;
    logic                  de_o_q, de_o_d;
    logic [DATA_WIDTH-1:0] data_o_q, data_o_d;
    logic                  sof_o_q, sof_o_d;
    logic                  eol_o_q, eol_o_d;
    logic                  eof_o_q, eof_o_d;

    // Window decode helpers
    logic [X_WIDTH-1:0] eff_end_x;
    logic [Y_WIDTH-1:0] eff_end_y;
    logic               in_win;
    logic               at_start_x, at_start_y, at_end_x, at_end_y;
    logic               vs_rise;

    // Staging capture and frame-boundary shadow load; a cfg_update that
    // lands on the load edge goes straight into the shadow set.
    always_comb begin
        vs_prev_d = vid.vs_i;
        vs_rise   = vid.vs_i & ~vs_prev_q;
        stg_d     = stg_q;
        shd_d     = shd_q;
        pending_d = pending_q;
        if (cfg_update) begin
            stg_d = cfg_in;
        end
        if (vs_rise && (pending_q || cfg_update)) begin
            shd_d     = cfg_update ? cfg_in : stg_q;
            pending_d = 1'b0;
        end else if (cfg_update) begin
            pending_d = 1'b1;
        end
        cfg_err_d = win_invalid(shd_d);
    end

    // Active-pixel counters: cleared by vs_i, advanced by de_i, raster wrap.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (vid.vs_i) begin
            x_d = '0;
            y_d = '0;
        end else if (vid.de_i) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + Y_WIDTH'(1);
            end else begin
                x_d = x_q + X_WIDTH'(1);
            end
        end
    end

    // Window membership and edge hits for the current (pre-increment) pixel.
    always_comb begin
        eff_end_x  = clamp_x(shd_q.ex);
        eff_end_y  = clamp_y(shd_q.ey);
        in_win     = ~cfg_err_q &&
                     (x_q >= shd_q.sx) && (x_q < eff_end_x) &&
                     (y_q >= shd_q.sy) && (y_q < eff_end_y);
        at_start_x = (x_q == shd_q.sx);
        at_start_y = (y_q == shd_q.sy);
        at_end_x   = (x_q == eff_end_x - X_WIDTH'(1));
        at_end_y   = (y_q == eff_end_y - Y_WIDTH'(1));
    end

    // Output stream: crop drops out-of-window pixels, mask fills them.
    always_comb begin
        vs_o_d   = vid.vs_i;
        de_o_d   = 1'b0;
        data_o_d = '0;
        sof_o_d  = 1'b0;
        eol_o_d  = 1'b0;
        eof_o_d  = 1'b0;
        if (shd_q.mode == MODE_CROP) begin
            if (vid.de_i && in_win) begin
                de_o_d   = 1'b1;
                data_o_d = vid.data_i;
                sof_o_d  = at_start_x && at_start_y;
                eol_o_d  = at_end_x;
                eof_o_d  = at_end_x && at_end_y;
            end
        end else if (vid.de_i) begin
            de_o_d   = 1'b1;
            data_o_d = in_win ? vid.data_i : FILL_VALUE;
            sof_o_d  = (x_q == '0) && (y_q == '0);
            eol_o_d  = (x_q == H_LAST);
            eof_o_d  = (x_q == H_LAST) && (y_q == V_LAST);
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_q     <= WIN_RESET;
            shd_q     <= WIN_RESET;
            pending_q <= 1'b0;
            vs_prev_q <= 1'b0;
            cfg_err_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            vs_o_q    <= 1'b0;
            de_o_q    <= 1'b0;
            data_o_q  <= '0;
            sof_o_q   <= 1'b0;
            eol_o_q   <= 1'b0;
            eof_o_q   <= 1'b0;
        end else begin
            stg_q     <= stg_d;
            shd_q     <= shd_d;
            pending_q <= pending_d;
            vs_prev_q <= vs_prev_d;
            cfg_err_q <= cfg_err_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vs_o_q    <= vs_o_d;
            de_o_q    <= de_o_d;
            data_o_q  <= data_o_d;
            sof_o_q   <= sof_o_d;
            eol_o_q   <= eol_o_d;
            eof_o_q   <= eof_o_d;
        end
    end

    assign vid.vs_o   = vs_o_q;
    assign vid.de_o   = de_o_q;
    assign vid.data_o = data_o_q;
    assign vid.sof_o  = sof_o_q;
    assign vid.eol_o  = eol_o_q;
    assign vid.eof_o  = eof_o_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_video_crop_win.sv
// Bench for video_crop_win on an 8x4 frame.
// Stimulus pushes the expected output pixel for every input pixel that should
// appear on de_o; a negedge monitor pops and compares whenever de_o is high
// and checks the idle stream otherwise.
module tb_video_crop_win;
    localparam int          HD   = 8;
    localparam int          VD   = 4;
    localparam int          XW   = 12;
    localparam int          YW   = 12;
    localparam int          DW   = 24;
    localparam logic [23:0] FILL = 24'hABCDEF;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [XW-1:0] cfg_start_x, cfg_end_x;
    logic [YW-1:0] cfg_start_y, cfg_end_y;
    logic          cfg_mode, cfg_update, cfg_err;
    logic          vs_d1;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    video_crop_win_if #(.DATA_WIDTH(DW)) vif ();

    video_crop_win #(
        .H_DISP(HD), .V_DISP(VD), .X_WIDTH(XW), .Y_WIDTH(YW),
        .DATA_WIDTH(DW), .FILL_VALUE(FILL)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_start_x(cfg_start_x), .cfg_start_y(cfg_start_y),
        .cfg_end_x(cfg_end_x), .cfg_end_y(cfg_end_y),
        .cfg_mode(cfg_mode), .cfg_update(cfg_update),
        .cfg_err(cfg_err),
        .vid(vif)
    );

    always #5 clk = ~clk;

    // vs_o reference: input vs one clock late
    always @(posedge clk or posedge rst) begin
        if (rst) vs_d1 <= 1'b0;
        else     vs_d1 <= vif.vs_i;
    end

    // Output monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            checks++;
            if (vif.vs_o !== vs_d1) begin
                errors++;
                $display("FAIL vs_o got %b want %b at %0t", vif.vs_o, vs_d1, $time);
            end
            if (vif.de_o === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pixel data_o=%h sof=%b eol=%b eof=%b at %0t",
                             vif.data_o, vif.sof_o, vif.eol_o, vif.eof_o, $time);
                end else begin
                    e = sb_q.pop_front();
                    if ({vif.data_o, vif.sof_o, vif.eol_o, vif.eof_o} !== {e.data, e.sof, e.eol, e.eof}) begin
                        errors++;
                        $display("FAIL pixel got data=%h sof=%b eol=%b eof=%b want data=%h sof=%b eol=%b eof=%b at %0t",
                                 vif.data_o, vif.sof_o, vif.eol_o, vif.eof_o,
                                 e.data, e.sof, e.eol, e.eof, $time);
                    end
                end
            end else begin
                checks++;
                if (vif.de_o !== 1'b0 || vif.data_o !== '0 ||
                    vif.sof_o !== 1'b0 || vif.eol_o !== 1'b0 || vif.eof_o !== 1'b0) begin
                    errors++;
                    $display("FAIL idle got de=%b data=%h sof=%b eol=%b eof=%b want all zero at %0t",
                             vif.de_o, vif.data_o, vif.sof_o, vif.eol_o, vif.eof_o, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vif.de_i   = 1'b0;
        vif.data_i = '0;
        repeat (n) tick();
    endtask

    task automatic set_cfg(input int sx, input int sy, input int ex, input int ey, input logic m);
        cfg_start_x = XW'(sx);
        cfg_start_y = YW'(sy);
        cfg_end_x   = XW'(ex);
        cfg_end_y   = YW'(ey);
        cfg_mode    = m;
    endtask

    task automatic load_cfg(input int sx, input int sy, input int ex, input int ey, input logic m);
        set_cfg(sx, sy, ex, ey, m);
        cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        idle(1);
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({vif.vs_o, vif.de_o, vif.data_o, vif.sof_o, vif.eol_o, vif.eof_o, cfg_err} !== '0) begin
            errors++;
            $display("FAIL %s got vs=%b de=%b data=%h sof=%b eol=%b eof=%b err=%b want all zero",
                     name, vif.vs_o, vif.de_o, vif.data_o, vif.sof_o, vif.eol_o, vif.eof_o, cfg_err);
        end
    endtask

    // One VS pulse then one full frame of pixels with data = index.
    // (sx,sy,ex,ey,m) is the window the bench expects to be active.
    task automatic run_frame(input int sx, input int sy, input int ex, input int ey,
                             input logic m, input logic err_exp,
                             input int upd_at, input int rst_at, input string name);
        int   cex, cey, x, y;
        bit   valid, inw;
        exp_t e;
        cex   = (ex > HD) ? HD : ex;
        cey   = (ey > VD) ? VD : ey;
        valid = (sx < cex) && (sy < cey);
        vif.vs_i = 1'b1;
        tick();
        tick();
        vif.vs_i = 1'b0;
        tick();
        checks++;
        if (cfg_err !== err_exp) begin
            errors++;
            $display("FAIL %s cfg_err got %b want %b", name, cfg_err, err_exp);
        end
        for (int i = 0; i < HD * VD; i++) begin
            x = i % HD;
            y = i / HD;
            vif.de_i   = 1'b1;
            vif.data_i = DW'(i);
            cfg_update = (i == upd_at);
            if (i == rst_at) begin
                @(negedge clk);
                #1 rst = 1'b1;
                #1 check_all_zero({name, "_async_rst"});
                vif.de_i   = 1'b0;
                vif.data_i = '0;
                cfg_update = 1'b0;
                repeat (3) tick();
                rst = 1'b0;
                break;
            end
            inw = valid && x >= sx && x < cex && y >= sy && y < cey;
            if (m == 1'b0) begin
                if (inw) begin
                    e.data = DW'(i);
                    e.sof  = (x == sx) && (y == sy);
                    e.eol  = (x == cex - 1);
                    e.eof  = (x == cex - 1) && (y == cey - 1);
                    sb_q.push_back(e);
                end
            end else begin
                e.data = inw ? DW'(i) : FILL;
                e.sof  = (i == 0);
                e.eol  = (x == HD - 1);
                e.eof  = (i == HD * VD - 1);
                sb_q.push_back(e);
            end
            tick();
        end
        cfg_update = 1'b0;
        idle(3);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_pixels got %0d outstanding want 0", name, sb_q.size());
        end
        sb_q.delete();
    endtask

    initial begin
        rst        = 1'b1;
        vif.vs_i   = 1'b0;
        vif.de_i   = 1'b0;
        vif.data_i = '0;
        cfg_update = 1'b0;
        set_cfg(0, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset_state");
        rst = 1'b0;
        idle(2);

        // Default full frame, crop
        run_frame(0, 0, HD, VD, 1'b0, 1'b0, -1, -1, "default");
        // Crop window 2,1,5,3
        load_cfg(2, 1, 5, 3, 1'b0);
        run_frame(2, 1, 5, 3, 1'b0, 1'b0, -1, -1, "crop");
        // Same window, mask
        load_cfg(2, 1, 5, 3, 1'b1);
        run_frame(2, 1, 5, 3, 1'b1, 1'b0, -1, -1, "mask");
        // Mid-frame update must wait for the next frame
        load_cfg(2, 1, 5, 3, 1'b0);
        set_cfg(5, 0, 6, 4, 1'b0);
        run_frame(2, 1, 5, 3, 1'b0, 1'b0, 16, -1, "dbuf_old");
        run_frame(5, 0, 6, 4, 1'b0, 1'b0, -1, -1, "dbuf_new");
        // End clamped to the active width
        load_cfg(6, 0, 20, 4, 1'b0);
        run_frame(6, 0, 20, 4, 1'b0, 1'b0, -1, -1, "clamp");
        // Empty window: crop emits nothing, mask fills all
        load_cfg(4, 0, 4, 4, 1'b0);
        run_frame(4, 0, 4, 4, 1'b0, 1'b1, -1, -1, "err_crop");
        load_cfg(4, 0, 4, 4, 1'b1);
        run_frame(4, 0, 4, 4, 1'b1, 1'b1, -1, -1, "err_mask");
        // Async reset mid-frame with an update pending
        load_cfg(2, 1, 5, 3, 1'b0);
        set_cfg(5, 0, 6, 4, 1'b1);
        run_frame(2, 1, 5, 3, 1'b0, 1'b0, 5, 13, "rst_mid");
        run_frame(0, 0, HD, VD, 1'b0, 1'b0, -1, -1, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
